// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROL shifter, up to STEP positions per clock.
// Optional rotate datapath: define ITERATIVE_SHIFTER_ROTATE_EN (otherwise op 11 acts as SLL).
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | waiting for start
// ST_SHIFT | stepping acc by min(STEP, rem) each cycle
// ST_DONE  | result_valid pulse; start here is accepted again
module iterative_shifter #(
  parameter int WIDTH   = 32,
  parameter int STEP    = 4,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               result_valid,
  output logic [WIDTH-1:0]   data_result
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [SHAMT_W:0] STEP_X = (SHAMT_W+1)'(STEP);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         op_q, op_d;
  logic [SHAMT_W-1:0] k;
  logic [WIDTH-1:0]   stepped;
  logic               accept;

  // When STEP == WIDTH the compare never holds (rem <= WIDTH-1), so k = rem.
  always_comb begin
    k = rem_q;
    if ({1'b0, rem_q} >= STEP_X) begin
      k = STEP_X[SHAMT_W-1:0];
    end
  end

  // One STEP-input mux per bit: pick the pre-shifted copy matching k.
  always_comb begin
    stepped = acc_q;
    for (int i = 1; i <= STEP; i++) begin
      if ({1'b0, k} == (SHAMT_W+1)'(i)) begin
        case (op_q)
          2'b01:   stepped = acc_q >> i;
          2'b10:   stepped = $unsigned($signed(acc_q) >>> i);
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
          2'b11:   stepped = (acc_q << i) | (acc_q >> (WIDTH - i));
`endif
          default: stepped = acc_q << i;
        endcase
      end
    end
  end

  assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    op_d    = op_q;
    case (state_q)
      ST_SHIFT: begin
        acc_d = stepped;
        rem_d = rem_q - k;
        if (rem_q == k) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (accept) begin
      acc_d   = data_operand;
      rem_d   = shamt;
      op_d    = op;
      state_d = (shamt == '0) ? ST_DONE : ST_SHIFT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

  assign busy         = (state_q == ST_SHIFT);
  assign result_valid = (state_q == ST_DONE);
  assign data_result  = acc_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Bench for iterative_shifter: three instances (STEP=4, 1, 32) driven in parallel,
// table vectors, hand-written handshake/reset sequences and random ops vs a reference model.
module tb_iterative_shifter;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_operand;
  logic [4:0]  shamt;
  logic [2:0]  busy_v;
  logic [2:0]  valid_v;
  logic [31:0] res_v [3];

  int checks   = 0;
  int failures = 0;
  int steps [3];
  int lat   [3];
  int bcnt  [3];
  logic [31:0] got [3];

  always #5 clock = ~clock;

  iterative_shifter #(.WIDTH(32), .STEP(4)) u_s4 (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .data_operand(data_operand), .shamt(shamt),
    .busy(busy_v[0]), .result_valid(valid_v[0]), .data_result(res_v[0]));

  iterative_shifter #(.WIDTH(32), .STEP(1)) u_s1 (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .data_operand(data_operand), .shamt(shamt),
    .busy(busy_v[1]), .result_valid(valid_v[1]), .data_result(res_v[1]));

  iterative_shifter #(.WIDTH(32), .STEP(32)) u_s32 (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .data_operand(data_operand), .shamt(shamt),
    .busy(busy_v[2]), .result_valid(valid_v[2]), .data_result(res_v[2]));

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [10];

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input int s);
    logic [63:0] d;
    d = {a, a} << s;
    case (o)
      2'd0: return a << s;
      2'd1: return a >> s;
      2'd2: return $unsigned($signed(a) >>> s);
      default: begin
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
        return d[63:32];
`else
        return a << s;
`endif
      end
    endcase
  endfunction

  function automatic int exp_latency(input int s, input int st);
    return (s + st - 1) / st + 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Starts one op on all instances; records latency, result and busy cycles per instance.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s);
    for (int j = 0; j < 3; j++) begin
      lat[j] = 0;
      got[j] = '0;
      bcnt[j] = 0;
    end
    op = o;
    data_operand = a;
    shamt = s;
    start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      start = 1'b0;
      for (int j = 0; j < 3; j++) begin
        if (valid_v[j] && lat[j] == 0) begin
          lat[j] = n;
          got[j] = res_v[j];
        end
        if (busy_v[j] && lat[j] == 0) bcnt[j]++;
      end
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
    end
  endtask

  task automatic verify(input string name, input logic [4:0] s, input logic [31:0] exp);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("%s result step%0d", name, steps[j]), got[j], exp);
      chk($sformatf("%s latency step%0d", name, steps[j]), lat[j],
          exp_latency(int'(s), steps[j]));
      chk($sformatf("%s busy_cycles step%0d", name, steps[j]), bcnt[j],
          exp_latency(int'(s), steps[j]) - 1);
    end
  endtask

  initial begin
    int pulses;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [4:0]  rs;
    steps[0] = 4;
    steps[1] = 1;
    steps[2] = 32;

    tbl[0] = '{2'd0, 32'h0000_0001, 5'd31, 32'h8000_0000};
    tbl[1] = '{2'd2, 32'h8000_0000, 5'd4,  32'hF800_0000};
    tbl[2] = '{2'd1, 32'h8000_0000, 5'd4,  32'h0800_0000};
    tbl[3] = '{2'd0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    tbl[4] = '{2'd1, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    tbl[5] = '{2'd2, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    tbl[6] = '{2'd3, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    tbl[7] = '{2'd2, 32'h7000_0000, 5'd31, 32'h0000_0000};
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    tbl[8] = '{2'd3, 32'h8000_0001, 5'd1,  32'h0000_0003};
    tbl[9] = '{2'd3, 32'h1234_5678, 5'd8,  32'h3456_7812};
`else
    tbl[8] = '{2'd3, 32'h8000_0001, 5'd1,  32'h0000_0002};
    tbl[9] = '{2'd3, 32'h1234_5678, 5'd8,  32'h3456_7800};
`endif

    reset = 1'b1;
    start = 1'b0;
    op = 2'd0;
    data_operand = '0;
    shamt = '0;
    tick();
    tick();
    chk("reset busy", {29'd0, busy_v}, 32'd0);
    chk("reset result_valid", {29'd0, valid_v}, 32'd0);
    for (int j = 0; j < 3; j++) chk($sformatf("reset data_result %0d", j), res_v[j], 32'd0);
    reset = 1'b0;
    tick();

    for (int t = 0; t < 10; t++) begin
      do_op(tbl[t].op, tbl[t].a, tbl[t].sh);
      verify($sformatf("vec%0d", t), tbl[t].sh, tbl[t].exp);
    end

    // start during SHIFT ignored, then back-to-back accept from DONE (STEP=4 instance)
    tick();
    op = 2'd0;
    data_operand = 32'h0000_0001;
    shamt = 5'd8;
    start = 1'b1;
    tick();
    op = 2'd1;
    data_operand = 32'hFFFF_FFFF;
    shamt = 5'd3;
    chk("ignore busy e1", {31'd0, busy_v[0]}, 32'd1);
    tick();
    start = 1'b0;
    chk("ignore acc e2", res_v[0], 32'h0000_0010);
    tick();
    chk("ignore valid e3", {31'd0, valid_v[0]}, 32'd1);
    chk("ignore result e3", res_v[0], 32'h0000_0100);
    op = 2'd1;
    data_operand = 32'h0000_00F0;
    shamt = 5'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b busy", {31'd0, busy_v[0]}, 32'd1);
    chk("b2b valid low", {31'd0, valid_v[0]}, 32'd0);
    tick();
    chk("b2b valid", {31'd0, valid_v[0]}, 32'd1);
    chk("b2b result", res_v[0], 32'h0000_000F);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // reset mid-SHIFT aborts with no later pulse
    op = 2'd0;
    data_operand = 32'h0000_0001;
    shamt = 5'd31;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("abort busy before", {29'd0, busy_v}, 32'd3);
    reset = 1'b1;
    tick();
    chk("abort busy", {29'd0, busy_v}, 32'd0);
    chk("abort result_valid", {29'd0, valid_v}, 32'd0);
    for (int j = 0; j < 3; j++) chk($sformatf("abort data_result %0d", j), res_v[j], 32'd0);
    reset = 1'b0;
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (valid_v != 3'd0) pulses++;
    end
    chk("abort stray pulses", pulses, 32'd0);

    for (int r = 0; r < 120; r++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rs = 5'($urandom_range(0, 31));
      do_op(ro, ra, rs);
      verify($sformatf("rand%0d op%0d sh%0d", r, ro, rs), rs, model(ro, ra, int'(rs)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
